// File: rtl/fetch_pkg.sv
// Shared definitions for the prefetching instruction-fetch front end.
//   INSTR_W        : instruction word width
//   PC_MAX_W       : widest PC the target helpers support; callers zero-extend
//                    their PC into this width and keep the low ADDR_W bits
//   fetch_state_e  : FETCH (normal) / FLUSH (stale responses still in flight)
//   branch_target  : pc + 4 + (sext(off16) << 2), wrapping
//   jump_target    : {pc[top:28], tgt26, 2'b00}
package fetch_pkg;

  localparam int INSTR_W  = 32;
  localparam int PC_MAX_W = 64;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  function automatic logic [PC_MAX_W-1:0] branch_target(
    input logic [PC_MAX_W-1:0] pc,
    input logic [15:0]         off16
  );
    return pc + PC_MAX_W'(4) + {{(PC_MAX_W-18){off16[15]}}, off16, 2'b00};
  endfunction

  // Keeps the PC's region bits above bit 27 and replaces everything below.
  function automatic logic [PC_MAX_W-1:0] jump_target(
    input logic [PC_MAX_W-1:0] pc,
    input logic [25:0]         tgt26
  );
    return (pc & {{(PC_MAX_W-28){1'b1}}, 28'b0}) |
           {{(PC_MAX_W-28){1'b0}}, tgt26, 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and a combinational head.
//   clk, reset      : clock, asynchronous active-high reset
//   push / wdata    : write; accepted when not full, or when full with a pop
//   pop             : remove head; ignored when empty (no bypass of a push)
//   clear           : discard all entries, overrides push and pop
//   rdata           : current head entry
//   full/empty/count: occupancy
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define which
  // entries are meaningful, so resetting the array would only add logic.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit_pf.sv
// Pipelined instruction fetch with a prefetch FIFO and redirect flushing.
//   clk, reset        : clock, asynchronous active-high reset
//   imem_req/addr/gnt : request channel; accepted on req && gnt
//   imem_rvalid/rdata : in-order responses, at least one cycle after grant
//   instr_valid/instr/instr_pc/instr_ready : decode handshake on FIFO head
//   redir_*           : single-cycle branch/jump redirect
//   busy_flush        : high while responses from before a redirect are dropped
// ADDR_W must be in 28..63; FIFO_DEPTH a power of two >= 2; MAX_OUTST >= 1.
module fetch_unit_pf
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter int                MAX_OUTST  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redir_valid,
  input  logic               redir_jump,
  input  logic [ADDR_W-1:0]  redir_pc,
  input  logic [15:0]        redir_off,
  input  logic [25:0]        redir_tgt,
  output logic               busy_flush
);

  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e              state, state_nxt;
  logic [OUT_W-1:0]          outstanding, outst_nxt;
  logic [OUT_W-1:0]          drop_cnt, drop_nxt;
  logic [ADDR_W-1:0]         fetch_pc, resp_pc, redir_target;
  logic [PC_MAX_W-1:0]       pc_wide, br_wide, jmp_wide;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic                      grant;
  logic [INSTR_W+ADDR_W-1:0] fifo_wdata, fifo_rdata;
  logic                      unused_ok;

  // Credit check counts in-flight requests against free FIFO slots, so every
  // response is guaranteed somewhere to land. Reset gates the request so the
  // output drops in the same cycle reset is asserted.
  assign imem_req = !reset && !redir_valid &&
                    (32'(outstanding) + 32'(fifo_count) < FIFO_DEPTH) &&
                    (32'(outstanding) < MAX_OUTST);
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;
  assign outst_nxt = outstanding + OUT_W'(grant) - OUT_W'(imem_rvalid);

  always_comb begin
    pc_wide                = '0;
    pc_wide[ADDR_W-1:0]    = redir_pc;
    br_wide                = branch_target(pc_wide, redir_off);
    jmp_wide               = jump_target(pc_wide, redir_tgt);
    redir_target           = redir_jump ? jmp_wide[ADDR_W-1:0] : br_wide[ADDR_W-1:0];
  end

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    drop_nxt  = drop_cnt;
    fifo_push = 1'b0;
    if (redir_valid) begin
      // A response arriving this cycle belongs to the old stream and is simply
      // not pushed; only what is still in flight afterwards must be dropped.
      drop_nxt  = outst_nxt;
      state_nxt = (outst_nxt != '0) ? FLUSH : FETCH;
    end else begin
      if (imem_rvalid) begin
        if (drop_cnt != '0) drop_nxt  = drop_cnt - OUT_W'(1);
        else                fifo_push = 1'b1;
      end
      if (state == FLUSH && drop_nxt == '0) state_nxt = FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
    end else begin
      outstanding <= outst_nxt;
      if (redir_valid) begin
        fetch_pc <= redir_target;
        resp_pc  <= redir_target;
      end else begin
        if (grant)     fetch_pc <= fetch_pc + ADDR_W'(4);
        if (fifo_push) resp_pc  <= resp_pc + ADDR_W'(4);
      end
    end
  end

  // The handshake in a redirect cycle still completes: decode has taken the
  // head, and the clear removes only what remains.
  assign fifo_pop   = instr_valid && instr_ready;
  assign fifo_wdata = {imem_rdata, resp_pc};

  sync_fifo #(
    .WIDTH (INSTR_W + ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (redir_valid),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_rdata[ADDR_W +: INSTR_W];
  assign instr_pc    = fifo_rdata[ADDR_W-1:0];
  assign busy_flush  = (state == FLUSH);

  // Full is implied by the credit check; the upper helper bits exceed ADDR_W.
  assign unused_ok = ^{fifo_full, br_wide[PC_MAX_W-1:ADDR_W], jmp_wide[PC_MAX_W-1:ADDR_W]};

endmodule

// File: tb/tb_fetch_unit_pf.sv
// Self-checking bench for fetch_unit_pf: an in-order memory model with
// programmable latency/hold, a queue-based reference model of the fetch
// stream, a per-cycle compare process, and directed scenarios with literal
// expectations.
module tb_fetch_unit_pf;

  localparam int          FIFO_DEPTH = 4;
  localparam int          MAX_OUTST  = 2;
  localparam logic [31:0] RESET_PC   = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redir_valid = 1'b0;
  logic        redir_jump = 1'b0;
  logic [31:0] redir_pc = '0;
  logic [15:0] redir_off = '0;
  logic [25:0] redir_tgt = '0;
  logic        busy_flush;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit_pf #(
    .ADDR_W     (32),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_OUTST  (MAX_OUTST),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redir_valid (redir_valid),
    .redir_jump  (redir_jump),
    .redir_pc    (redir_pc),
    .redir_off   (redir_off),
    .redir_tgt   (redir_tgt),
    .busy_flush  (busy_flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[17:2]};
  endfunction

  function automatic logic [31:0] exp_branch(input logic [31:0] pc, input logic [15:0] off);
    int o;
    o = int'($signed(off));
    return pc + 32'd4 + 32'(o * 4);
  endfunction

  function automatic logic [31:0] exp_jump(input logic [31:0] pc, input logic [25:0] tgt);
    return (pc & 32'hF000_0000) | (32'(tgt) * 32'd4);
  endfunction

  // ---------------- memory environment ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mem_q[$];
  int    lat  = 1;
  bit    hold = 1'b0;
  int    cyc  = 0;

  // ---------------- reference model ----------------
  logic [31:0] resp_q[$];   // issued, response not yet seen
  logic [31:0] buf_q[$];    // buffered for decode, in order
  logic [31:0] exp_fetch = RESET_PC;
  int          drop_n = 0;
  bit          m_req;

  // samples taken at the falling edge, consumed at the next rising edge
  bit          s_req, s_gnt, s_rvalid, s_ready, s_redir, s_jump;
  logic [31:0] s_addr, s_rpc;
  logic [15:0] s_off;
  logic [25:0] s_tgt;
  logic [31:0] pc_r, tgt_r;

  always @(negedge clk) begin
    if (reset) begin
      m_req = 1'b0;
      check("rst_imem_req", imem_req, 1'b0);
      check("rst_instr_valid", instr_valid, 1'b0);
      check("rst_busy_flush", busy_flush, 1'b0);
    end else begin
      m_req = !redir_valid && (resp_q.size() + buf_q.size() < FIFO_DEPTH) &&
              (resp_q.size() < MAX_OUTST);
      check("imem_req", imem_req, m_req);
      if (m_req) check("imem_addr", imem_addr, exp_fetch);
      check("instr_valid", instr_valid, buf_q.size() > 0);
      if (buf_q.size() > 0) begin
        check("instr_pc", instr_pc, buf_q[0]);
        check("instr", instr, mem_word(buf_q[0]));
      end
      check("busy_flush", busy_flush, drop_n > 0);
    end
    s_req    = imem_req;
    s_addr   = imem_addr;
    s_gnt    = imem_gnt;
    s_rvalid = imem_rvalid;
    s_ready  = instr_ready;
    s_redir  = redir_valid;
    s_jump   = redir_jump;
    s_rpc    = redir_pc;
    s_off    = redir_off;
    s_tgt    = redir_tgt;
  end

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      resp_q.delete();
      buf_q.delete();
      mem_q.delete();
      exp_fetch = RESET_PC;
      drop_n    = 0;
    end else begin
      if (buf_q.size() > 0 && s_ready) void'(buf_q.pop_front());
      if (s_rvalid && resp_q.size() > 0) begin
        pc_r = resp_q.pop_front();
        if (!s_redir) begin
          if (drop_n > 0) drop_n--;
          else            buf_q.push_back(pc_r);
        end
      end
      if (m_req && s_gnt) begin
        resp_q.push_back(exp_fetch);
        exp_fetch += 32'd4;
      end
      if (s_redir) begin
        tgt_r     = s_jump ? exp_jump(s_rpc, s_tgt) : exp_branch(s_rpc, s_off);
        buf_q.delete();
        exp_fetch = tgt_r;
        drop_n    = resp_q.size();
      end
      if (s_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
      if (s_req && s_gnt) mem_q.push_back('{s_addr, cyc + lat});
    end
    #2;
    imem_rvalid = !reset && !hold && mem_q.size() > 0 && mem_q[0].due <= cyc + 1;
    imem_rdata  = imem_rvalid ? mem_word(mem_q[0].addr) : 32'h0;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_redir(input logic j, input logic [31:0] pc,
                             input logic [15:0] off, input logic [25:0] tgt);
    redir_valid = 1'b1;
    redir_jump  = j;
    redir_pc    = pc;
    redir_off   = off;
    redir_tgt   = tgt;
  endtask

  task automatic expect_next_pc(input string name, input logic [31:0] exp);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        seen = 1'b1;
        check(name, instr_pc, exp);
      end
    end
    if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  logic [31:0] g_addr [4];
  logic [31:0] d_pc   [4];
  int          g_idx [4];
  int          d_idx [4];
  int          n_g, n_d, busy_n;
  bit          got_pc, got_req;
  logic [31:0] first_pc;

  initial begin
    // ---- reset, then straight-line fetch with a 1-cycle memory ----
    imem_gnt    = 1'b1;
    instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    n_g = 0;
    n_d = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt && n_g < 4) begin g_addr[n_g] = imem_addr; g_idx[n_g] = i; n_g++; end
      if (instr_valid && instr_ready && n_d < 4) begin d_pc[n_d] = instr_pc; d_idx[n_d] = i; n_d++; end
    end
    check("line_grants", n_g, 4);
    check("line_delivered", n_d, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < n_g) check("line_imem_addr", g_addr[k], 32'(4 * k));
      if (k < n_d) check("line_instr_pc", d_pc[k], 32'(4 * k));
    end
    if (n_g == 4 && n_d == 4) begin
      check("line_fill_latency", d_idx[0] - g_idx[0], 2);
      check("line_sustained", d_idx[3] - d_idx[0], 3);
    end

    // ---- backpressure ----
    step();
    instr_ready = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp_instr_valid", instr_valid, 1'b1);
    check("bp_imem_req", imem_req, 1'b0);
    step();
    instr_ready = 1'b1;
    lat = 2;
    for (int i = 0; i < 14; i++) begin
      step();
      imem_gnt = i[0];
    end
    imem_gnt = 1'b1;
    lat = 1;
    repeat (4) step();

    // ---- branch with two requests in flight ----
    hold = 1'b1;
    repeat (6) step();
    @(negedge clk);
    check("br_pre_req_blocked", imem_req, 1'b0);
    step();
    drive_redir(1'b0, 32'h0000_0010, 16'hFFFD, 26'h0);
    step();
    redir_valid = 1'b0;
    hold = 1'b0;
    busy_n = 0;
    got_pc = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy_flush) busy_n++;
      if (instr_valid && !got_pc) begin got_pc = 1'b1; first_pc = instr_pc; end
    end
    check("br_busy_cycles", busy_n, 2);
    check("br_first_seen", got_pc, 1'b1);
    if (got_pc) check("br_first_pc", first_pc, 32'h0000_0008);

    // ---- jump with a full FIFO and decode stalled ----
    step();
    instr_ready = 1'b0;
    repeat (6) step();
    drive_redir(1'b1, 32'h1000_0010, 16'h0, 26'h000001);
    step();
    redir_valid = 1'b0;
    repeat (2) step();
    instr_ready = 1'b1;
    expect_next_pc("jmp_first_pc", 32'h1000_0004);

    // ---- redirect coincident with handshake and with a response ----
    repeat (6) step();
    @(negedge clk);
    check("co_pre_valid_rvalid", {instr_valid, imem_rvalid}, 2'b11);
    step();
    drive_redir(1'b0, 32'h1000_0020, 16'h0005, 26'h0);
    step();
    redir_valid = 1'b0;
    expect_next_pc("co_first_pc", 32'h1000_0038);
    step();
    imem_gnt = 1'b0;
    repeat (4) step();
    @(negedge clk);
    check("co_drained_req", imem_req, 1'b1);
    check("co_drained_busy", busy_flush, 1'b0);
    step();
    imem_gnt = 1'b1;
    repeat (4) step();

    // ---- redirect during FLUSH, then async reset mid-FLUSH ----
    hold = 1'b1;
    repeat (6) step();
    drive_redir(1'b0, 32'h0000_0040, 16'h0000, 26'h0);
    step();
    drive_redir(1'b0, 32'h0000_0080, 16'h0001, 26'h0);
    step();
    redir_valid = 1'b0;
    @(posedge clk);
    #2;
    check("rst_pre_busy", busy_flush, 1'b1);
    #1 reset = 1'b1;
    hold = 1'b0;
    #1;
    check("rst_async_req", imem_req, 1'b0);
    check("rst_async_valid", instr_valid, 1'b0);
    check("rst_async_busy", busy_flush, 1'b0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    got_req = 1'b0;
    for (int i = 0; i < 10 && !got_req; i++) begin
      @(negedge clk);
      if (imem_req) begin
        got_req = 1'b1;
        check("rst_restart_addr", imem_addr, RESET_PC);
      end
    end
    if (!got_req) check("rst_restart_timeout", 64'd0, 64'd1);
    expect_next_pc("rst_first_pc", RESET_PC);
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
